// File: rtl/miriscv_imem_adapter.sv
// Instruction-memory adapter: turns fetch requests into a bus with grant/in-order
// rvalid, holds unaccepted requests, and drops in-flight responses across a flush.
// Optional alignment check enabled by defining MIRISCV_IMEM_ALIGN_CHECK_EN.
package miriscv_pkg;
  parameter int XLEN = 32;
endpackage

module miriscv_imem_adapter #(
  parameter int XLEN            = miriscv_pkg::XLEN,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            instr_req_i,
  input  logic [XLEN-1:0] instr_addr_i,
  input  logic            flush_i,
  output logic            instr_rvalid_o,
  output logic [XLEN-1:0] instr_rdata_o,
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
  output logic            instr_misalign_o,
`endif
  output logic            stall_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
  localparam logic [1:0]      MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      drop_q, drop_d;
  logic [XLEN-1:0] hold_addr_q;
  logic            grant, rsp, fwd;
  logic            misalign_hit;

`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |instr_addr_i[1:0];
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_addr_o   = instr_addr_i;
    stall_o      = 1'b0;
    misalign_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req_o = instr_req_i & (cnt_q < MAX_CNT) & ~flush_i;
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
        // Misaligned fetches are answered locally, only once the bus is drained
        // so the local answer cannot overtake bus responses.
        mem_req_o    = mem_req_o & ~misaligned;
        misalign_hit = instr_req_i & misaligned & ~flush_i & (cnt_q == 2'd0);
`endif
        if (mem_req_o && !mem_gnt_i) state_d = HOLD;
      end
      HOLD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = hold_addr_q;
        if (mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_o = (state_q == HOLD) | (instr_req_i & (cnt_q == MAX_CNT)) |
              ((state_q == IDLE) & mem_req_o & ~mem_gnt_i);
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
    stall_o = stall_o | ((state_q == IDLE) & instr_req_i & misaligned & (cnt_q != 2'd0));
`endif
    if (arst_i) begin
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
    end
  end

  assign grant = mem_req_o & mem_gnt_i;
  assign rsp   = mem_rvalid_i & (cnt_q != 2'd0);
  assign fwd   = rsp & ~flush_i & (drop_q == 2'd0);

  always_comb begin
    unique case ({grant, rsp})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // On flush, everything already on the bus (plus a still-held request) is stale.
  always_comb begin
    drop_d = drop_q;
    if (flush_i)                        drop_d = cnt_d + {1'b0, state_d == HOLD};
    else if (rsp && (drop_q != 2'd0))   drop_d = drop_q - 2'd1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q       <= 2'd0;
      drop_q      <= 2'd0;
      hold_addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      if (state_q == IDLE && state_d == HOLD) hold_addr_q <= instr_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= NOP;
    end else begin
      instr_rvalid_o <= fwd | misalign_hit;
      if (fwd)               instr_rdata_o <= mem_rdata_i;
      else if (misalign_hit) instr_rdata_o <= NOP;
    end
  end

`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) instr_misalign_o <= 1'b0;
    else        instr_misalign_o <= misalign_hit;
  end
`endif

endmodule

// File: tb/tb_miriscv_imem_adapter.sv
// Scoreboard bench for miriscv_imem_adapter: directed scenarios plus random traffic
// checked against a transaction-level model of pending/outstanding/dropped fetches.
module tb_miriscv_imem_adapter;
  localparam int MAX = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_i = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        stall_o, mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
  logic        instr_misalign_o;
`endif

  miriscv_imem_adapter #(.XLEN(32), .MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .arst_i(arst_i), .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .flush_i(flush_i), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
    .instr_misalign_o(instr_misalign_o),
`endif
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct { int due; logic [31:0] data; bit mis; } exp_t;
  exp_t expq[$];
  logic [31:0] last_data = NOP;

  // Reference model: fetches granted but unanswered, responses to discard,
  // and a request shown on the bus but not yet accepted.
  int          m_cnt = 0, m_drop = 0;
  bit          m_pend = 0;
  logic [31:0] m_paddr = '0;

  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].due < cyc) begin
      tests++; fails++;
      $display("FAIL missing_rvalid: got none expected %0h (due %0d)", expq[0].data, expq[0].due);
      e = expq.pop_front();
    end
    if (instr_rvalid_o === 1'b1) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        chk("rdata", instr_rdata_o, e.data);
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
        chk("misalign", instr_misalign_o, e.mis);
`endif
        last_data = e.data;
      end else begin
        tests++; fails++;
        $display("FAIL unexpected_rvalid: got rvalid=1 data %0h expected rvalid=0 (cycle %0d)",
                 instr_rdata_o, cyc);
      end
    end else begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        tests++; fails++;
        $display("FAIL missing_rvalid: got rvalid=0 expected data %0h (cycle %0d)", expq[0].data, cyc);
        e = expq.pop_front();
      end
      chk("rdata_hold", instr_rdata_o, last_data);
    end
  end

  task automatic step(input bit req, input logic [31:0] addr, input bit gnt,
                      input bit rv, input logic [31:0] rd, input bit fl);
    bit exp_req, exp_stall, grant, rsp, mis, pend_next;
    int cnt_next;
    exp_t e;
    @(posedge clk); #1;
    instr_req_i = req; instr_addr_i = addr; mem_gnt_i = gnt;
    mem_rvalid_i = rv; mem_rdata_i = rd; flush_i = fl;
    #1;
    mis = 0;
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
    mis = !m_pend && req && (addr[1:0] != 2'b00);
`endif
    exp_req   = m_pend || (req && m_cnt < MAX && !fl && !mis);
    exp_stall = m_pend || (req && m_cnt == MAX) || (!m_pend && exp_req && !gnt) ||
                (mis && m_cnt != 0);
    chk("mem_req", mem_req_o, exp_req);
    chk("stall", stall_o, exp_stall);
    if (exp_req) chk("mem_addr", mem_addr_o, m_pend ? m_paddr : addr);
    grant     = exp_req && gnt;
    rsp       = rv && (m_cnt > 0);
    cnt_next  = m_cnt + int'(grant) - int'(rsp);
    pend_next = exp_req && !gnt;
    if (rsp && !fl) begin
      if (m_drop > 0) m_drop--;
      else begin e.due = cyc + 1; e.data = rd; e.mis = 0; expq.push_back(e); end
    end
    if (fl) m_drop = cnt_next + int'(pend_next);
    if (mis && !fl && m_cnt == 0) begin e.due = cyc + 1; e.data = NOP; e.mis = 1; expq.push_back(e); end
    if (!m_pend && pend_next) m_paddr = addr;
    m_pend = pend_next;
    m_cnt  = cnt_next;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    arst_i = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h40; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    expq.delete(); last_data = NOP;
    m_cnt = 0; m_drop = 0; m_pend = 0;
    #1;
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_rvalid", instr_rvalid_o, 1'b0);
    chk("rst_rdata", instr_rdata_o, NOP);
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0; instr_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int guard;
    #1 arst_i = 1'b1;
    instr_req_i = 1'b1;
    #1;
    chk("por_mem_req", mem_req_o, 1'b0);
    chk("por_stall", stall_o, 1'b0);
    chk("por_rvalid", instr_rvalid_o, 1'b0);
    chk("por_rdata", instr_rdata_o, NOP);
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0; instr_req_i = 1'b0;

    // single granted fetch
    step(1, 32'h100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEADBEEF, 0);
    step(0, 0, 0, 0, 0, 0);
    // held request ignores new fetch addresses until granted
    step(1, 32'h200, 0, 0, 0, 0);
    step(1, 32'h300, 0, 0, 0, 0);
    step(1, 32'h400, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h11111111, 0);
    // outstanding limit
    step(1, 32'h500, 1, 0, 0, 0);
    step(1, 32'h504, 1, 0, 0, 0);
    step(1, 32'h508, 1, 0, 0, 0);
    step(1, 32'h508, 1, 1, 32'hA0A0A0A0, 0);
    step(1, 32'h508, 1, 1, 32'hB1B1B1B1, 0);
    step(0, 0, 0, 1, 32'hC2C2C2C2, 0);
    // flush drops both in-flight responses
    step(1, 32'h600, 1, 0, 0, 0);
    step(1, 32'h604, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'hBAD00001, 0);
    step(0, 0, 0, 1, 32'hBAD00002, 0);
    step(1, 32'h700, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h13579BDF, 0);
    // flush while a request is held: that request's response is dropped too
    step(1, 32'h800, 1, 0, 0, 0);
    step(1, 32'h804, 0, 0, 0, 0);
    step(1, 32'h808, 0, 1, 32'hBAD00003, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'hBAD00004, 0);
    step(1, 32'h900, 1, 0, 0, 0);
    step(0, 0, 0, 1, 32'h2468ACE0, 0);
    // reset while holding with one outstanding, then a stray response
    step(1, 32'hA00, 1, 0, 0, 0);
    step(1, 32'hA04, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 32'hBAD00005, 0);
    step(0, 0, 0, 0, 0, 0);
`ifdef MIRISCV_IMEM_ALIGN_CHECK_EN
    step(1, 32'h102, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      a = $urandom() & 32'hFFFF_FFFC;
      step(($urandom_range(0, 9) < 7), a, $urandom_range(0, 1),
           (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0),
           $urandom(), ($urandom_range(0, 19) == 0));
    end

    guard = 0;
    while ((m_cnt > 0 || m_pend) && guard < 20) begin
      step(0, 0, 1, 1, $urandom(), 0);
      guard++;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
